piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  data_in holds a word to transfer.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 serial_output  output  1  registered serial bit stream feeding the downstream SISO serial_input.
REQ-009 bit_valid  output  1  serial_output carries a frame bit this cycle.
REQ-010 frame_done  output  1  one-cycle pulse on the last bit of a frame.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and (with the macro only) PARITY.
REQ-012 Accept: a word SHALL be captured on a rising edge where in_valid and in_ready are both 1; no other edge captures data_in.
REQ-013 in_ready SHALL be 1 in IDLE and during the final bit cycle of a frame; otherwise 0.
REQ-014 The first bit of a captured word SHALL appear on serial_output in the cycle after the accepting edge (latency 1).
REQ-015 SHIFT SHALL output one data bit per cycle for exactly WIDTH consecutive cycles, in the order set by MSB_FIRST.
REQ-016 bit_valid SHALL be 1 exactly while a data or parity bit is driven; in IDLE, bit_valid=0 and serial_output=0.
REQ-017 Back-to-back: a word accepted during a final bit cycle SHALL start the next cycle with no idle gap.
REQ-018 With no accept during the final bit cycle, the FSM SHALL return to IDLE the next cycle.
REQ-019 frame_done SHALL assert for exactly the cycle carrying the last bit (last data bit, or the parity bit when enabled).
REQ-020 data_in changes after the accepting edge SHALL NOT affect the frame in flight.
REQ-021 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL reload to 0 on every accept.

Reset
REQ-022 While rst=1: state=IDLE, serial_output=0, bit_valid=0, frame_done=0, in_ready=0, counter and shift register 0.
REQ-023 Reset mid-frame SHALL abort the frame: no remaining bits and no frame_done.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-025 Macro PISO_PARITY_EN defined: after the WIDTH data bits, the PARITY state SHALL output one even-parity bit (XOR of the word) with bit_valid=1; the frame is WIDTH+1 bits.
REQ-026 Macro PISO_PARITY_EN undefined: no PARITY state and no parity logic; the frame is WIDTH bits.

Structure
REQ-027 Package piso_pkg SHALL hold the FSM state typedef and a localparam PARITY_BITS, which is 1 or 0 depending on PISO_PARITY_EN.
REQ-028 The bit counter with terminal-count flag SHALL be a sub-module named piso_bit_counter; everything else stays in piso_serializer.

Verification
REQ-029 WIDTH=4, MSB_FIRST=1, accept 4'b1101 -> serial_output 1,1,0,1 over the next 4 cycles, bit_valid=1 for 4 cycles, frame_done on the 4th.
REQ-030 MSB_FIRST=0, accept 4'b1101 -> serial_output 1,0,1,1; frame_done on the 4th bit.
REQ-031 Hold in_valid=1 with 4'b1011 then 4'b0110 -> 8 contiguous bits 1,0,1,1,0,1,1,0, in_ready high only in the 4th-bit cycle, two frame_done pulses.
REQ-032 Present in_valid=1 while busy (bits 1-3) -> no capture; the word is taken only when in_ready=1.
REQ-033 Assert rst after 2 bits of 4'b1101 -> next cycle serial_output=0 and bit_valid=0, no frame_done, in_ready=1 in the first cycle after release.
REQ-034 PISO_PARITY_EN defined, accept 4'b1101 -> 1,1,0,1,1 (parity bit 1), frame_done on the 5th bit; accept 4'b1001 -> parity bit 0.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg -- shared types and constants for the PISO serializer.
//
// Holds the serializer FSM state type and PARITY_BITS, the number of bits a
// frame carries after its data bits.
//
// Build option: define PISO_PARITY_EN to append one even-parity bit to every
// frame. This adds the PARITY state and the parity helper function. Without
// the macro, neither is present.
package piso_pkg;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    // Even parity of a word; narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction
`else
    localparam int PARITY_BITS = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;
`endif

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter -- data-bit position counter for the PISO serializer.
//
// count_o is the index of the data bit currently on the serial line.
// term_o flags the final data bit (index WIDTH-1).
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears the count
//   clr_i    reload the count to 0 (a new word is accepted)
//   en_i     advance to the next bit position
//   count_o  current bit index, ceil(log2(WIDTH+1)) bits
//   term_o   count_o == WIDTH-1
module piso_bit_counter #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          term_o
);

    logic [CW-1:0] count_q;

    // Count register: reset and reload take priority over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CW{1'b0}};
        end else if (clr_i) begin
            count_q <= {CW{1'b0}};
        end else if (en_i) begin
            count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer -- parallel-in / serial-out serializer with ready/valid input.
//
// A word is accepted on an edge where in_valid and in_ready are both high.
// The first bit appears on the next cycle. One bit is sent per cycle after
// that. A word accepted during a frame's final bit continues the stream with
// no gap.
//
// Build option: define PISO_PARITY_EN to append one even-parity bit per frame.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset (aborts any frame in flight)
//   data_in        parallel word (WIDTH bits)
//   in_valid       data_in holds a word to transfer
//   in_ready       a word can be accepted this cycle
//   serial_output  registered serial bit
//   bit_valid      serial_output carries a frame bit
//   frame_done     high on the last bit of a frame
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_output,
    output logic             bit_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH + 1);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             serial_q, serial_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             ready_q, ready_d;

    logic             accept_s;
    logic             load_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic [CW-1:0]    cnt_s;
    logic             cnt_term_s;

    piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr_s),
        .en_i    (cnt_en_s),
        .count_o (cnt_s),
        .term_o  (cnt_term_s)
    );

    // ready_q predicts readiness for the coming cycle. Gating it with rst keeps
    // in_ready low during reset and lets it rise immediately when reset is released.
    assign in_ready = ready_q & ~rst;
    assign accept_s = in_valid & in_ready;

`ifdef PISO_PARITY_EN
    logic parity_q;

    // Parity is taken from the whole word at accept time, because the shift register later loses bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (accept_s) begin
            parity_q <= even_parity(32'(data_in));
        end else begin
            parity_q <= parity_q;
        end
    end
`endif

    // Next-state logic. The *_d values describe the cycle after the coming edge.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        serial_d     = 1'b0;
        bit_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        ready_d      = 1'b0;
        cnt_clr_s    = 1'b0;
        cnt_en_s     = 1'b0;
        load_s       = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (!cnt_term_s) begin
                    // The head bit of shreg_q is on the line now. Shift it out and present the next one.
                    if (MSB_FIRST != 0) begin
                        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                        serial_d = shreg_q[WIDTH-2];
                    end else begin
                        shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
                        serial_d = shreg_q[1];
                    end
                    bit_valid_d = 1'b1;
                    cnt_en_s    = 1'b1;
                    // The next bit is the frame's last bit only when no parity bit follows.
                    if ((cnt_s == CW'(WIDTH - 2)) && (PARITY_BITS == 0)) begin
                        frame_done_d = 1'b1;
                        ready_d      = 1'b1;
                    end else begin
                        frame_done_d = 1'b0;
                        ready_d      = 1'b0;
                    end
                end else begin
`ifdef PISO_PARITY_EN
                    state_d      = PARITY;
                    serial_d     = parity_q;
                    bit_valid_d  = 1'b1;
                    frame_done_d = 1'b1;
                    ready_d      = 1'b1;
`else
                    state_d = IDLE;
                    ready_d = 1'b1;
                    if (accept_s) begin
                        load_s = 1'b1;
                    end else begin
                        load_s = 1'b0;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                ready_d = 1'b1;
                if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        // Loading a word overrides the branch results above, so back-to-back frames have no gap.
        if (load_s) begin
            state_d      = SHIFT;
            shreg_d      = data_in;
            serial_d     = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
            bit_valid_d  = 1'b1;
            frame_done_d = 1'b0;
            ready_d      = 1'b0;
            cnt_clr_s    = 1'b1;
        end else begin
            cnt_clr_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= {WIDTH{1'b0}};
            serial_q     <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            serial_q     <= serial_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
            ready_q      <= ready_d;
        end
    end

    assign serial_output = serial_q;
    assign bit_valid     = bit_valid_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer.
// It drives one MSB-first instance and one LSB-first instance from the same inputs.
// A queue-based model of the expected bit stream is checked on every cycle.
// Table-driven frames and directed corner-case sequences are layered on top.
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = W + PB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] data_in;
    logic         ready_m, serial_m, bv_m, fd_m;
    logic         ready_l, serial_l, bv_l, fd_l;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each queue holds the bits still to appear, and element 0 is on the line now.
    bit q_m[$];
    bit q_l[$];

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] exp_msb;   // bits in send order, first bit leftmost
        logic [W-1:0] exp_lsb;
        logic         exp_par;
    } vec_t;
    vec_t vecs[6];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(ready_m), .serial_output(serial_m), .bit_valid(bv_m), .frame_done(fd_m));

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(ready_l), .serial_output(serial_l), .bit_valid(bv_l), .frame_done(fd_l));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) q_m.push_back(w[i]);
        for (int i = 0; i < W; i++) q_l.push_back(w[i]);
        if (PB == 1) begin
            q_m.push_back(^w);
            q_l.push_back(^w);
        end
    endtask

    task automatic model_step();
        bit acc;
        if (rst) begin
            q_m.delete();
            q_l.delete();
        end else begin
            acc = in_valid && (q_m.size() <= 1);
            if (q_m.size() > 0) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (acc) push_frame(data_in);
        end
    endtask

    task automatic check_cycle();
        logic e_bv, e_sm, e_sl, e_fd, e_rdy;
        e_bv  = (q_m.size() > 0);
        e_sm  = e_bv ? q_m[0] : 1'b0;
        e_sl  = e_bv ? q_l[0] : 1'b0;
        e_fd  = (q_m.size() == 1);
        e_rdy = (q_m.size() <= 1) && !rst;
        chk("serial_msb", serial_m, e_sm);
        chk("serial_lsb", serial_l, e_sl);
        chk("bit_valid_msb", bv_m, e_bv);
        chk("bit_valid_lsb", bv_l, e_bv);
        chk("frame_done_msb", fd_m, e_fd);
        chk("frame_done_lsb", fd_l, e_fd);
        chk("in_ready_msb", ready_m, e_rdy);
        chk("in_ready_lsb", ready_l, e_rdy);
    endtask

    // One clock: the model consumes the inputs at the edge, then outputs are compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && q_m.size() != 0; i++) tick();
        chk("idle_reached", bv_m, 1'b0);
    endtask

    initial begin
        logic [W-1:0]      got_m, got_l;
        logic              got_p;
        logic [2*FL-1:0]   seq, exp_seq;
        int                rdy_cnt, fd_cnt;

        vecs[0] = '{data: 4'b1101, exp_msb: 4'b1101, exp_lsb: 4'b1011, exp_par: 1'b1};
        vecs[1] = '{data: 4'b1001, exp_msb: 4'b1001, exp_lsb: 4'b1001, exp_par: 1'b0};
        vecs[2] = '{data: 4'b1011, exp_msb: 4'b1011, exp_lsb: 4'b1101, exp_par: 1'b1};
        vecs[3] = '{data: 4'b0110, exp_msb: 4'b0110, exp_lsb: 4'b0110, exp_par: 1'b0};
        vecs[4] = '{data: 4'b0001, exp_msb: 4'b0001, exp_lsb: 4'b1000, exp_par: 1'b1};
        vecs[5] = '{data: 4'b1110, exp_msb: 4'b1110, exp_lsb: 4'b0111, exp_par: 1'b1};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; data_in = 4'b0000;
        tick();
        tick();
        chk("rst_ready", ready_m, 1'b0);
        chk("rst_bit_valid", bv_m, 1'b0);
        rst = 1'b0;
        #1 chk("post_rst_ready", ready_m, 1'b1);

        // Table-driven frames; data_in is corrupted after the accept to prove it was captured.
        for (int v = 0; v < 6; v++) begin
            wait_idle();
            data_in = vecs[v].data; in_valid = 1'b1;
            tick();
            in_valid = 1'b0; data_in = ~vecs[v].data;
            got_m = '0; got_l = '0; got_p = 1'b0;
            got_m[W-1] = serial_m; got_l[W-1] = serial_l;
            for (int k = 1; k < FL; k++) begin
                tick();
                if (k < W) begin
                    got_m[W-1-k] = serial_m;
                    got_l[W-1-k] = serial_l;
                end else begin
                    got_p = serial_m;
                end
            end
            chk("tbl_msb_bits", got_m, vecs[v].exp_msb);
            chk("tbl_lsb_bits", got_l, vecs[v].exp_lsb);
            chk("tbl_last_frame_done", fd_m, 1'b1);
`ifdef PISO_PARITY_EN
            chk("tbl_parity", got_p, vecs[v].exp_par);
`endif
            tick();
            chk("tbl_return_idle", bv_m, 1'b0);
        end

        // Back-to-back: in_valid held with 1011 then 0110
        wait_idle();
        in_valid = 1'b1; data_in = 4'b1011;
        tick();
        data_in = 4'b0110;
        seq = '0; rdy_cnt = 0; fd_cnt = 0;
        for (int idx = 0; idx < 2 * FL; idx++) begin
            if (idx > 0) tick();
            seq[2*FL-1-idx] = serial_m;
            if (idx < FL && ready_m) rdy_cnt++;
            if (fd_m) fd_cnt++;
            if (idx == FL) in_valid = 1'b0;
        end
`ifdef PISO_PARITY_EN
        exp_seq = 10'b1011101100;
`else
        exp_seq = 8'b10110110;
`endif
        chk("b2b_bits", seq, exp_seq);
        chk("b2b_ready_cycles", rdy_cnt, 1);
        chk("b2b_frame_done_pulses", fd_cnt, 2);

        // in_valid while busy must not capture
        wait_idle();
        in_valid = 1'b1; data_in = 4'b1101;
        tick();
        data_in = 4'b0010;
        got_m = '0; got_m[W-1] = serial_m;
        for (int k = 1; k < FL; k++) begin
            if (k == FL - 1) in_valid = 1'b0;
            tick();
            if (k < W) got_m[W-1-k] = serial_m;
        end
        chk("busy_bits", got_m, 4'b1101);
        tick();
        chk("busy_no_capture", bv_m, 1'b0);

        // Reset after two bits of 1101
        wait_idle();
        in_valid = 1'b1; data_in = 4'b1101;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_abort_serial", serial_m, 1'b0);
        chk("rst_abort_bv", bv_m, 1'b0);
        chk("rst_abort_fd", fd_m, 1'b0);
        rst = 1'b0;
        #1 chk("rst_release_ready", ready_m, 1'b1);
        tick();
        chk("rst_no_tail_bv", bv_m, 1'b0);
        chk("rst_no_tail_fd", fd_m, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 39) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            data_in  = W'($urandom);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
